// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding-request instruction fetch stage
module fetch_unit #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = {XLEN{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcsrc,
    input  logic [XLEN-1:0]  pctarget,
    input  logic             stall,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [6:0]       op,
    output logic [2:0]       funct3,
    output logic             funct7b5,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pcplus4,
    output logic             instr_valid,
    output logic [31:0]      instret
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'd4};

    state_t            r_state;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic [31:0]       r_instret;
    logic              r_imem_req;
    logic              r_instr_valid;

    logic [XLEN-1:0]   w_pcplus4;
    logic [XLEN-1:0]   w_target;
    logic              w_unused_target_lsbs;

    // Sequential pc increment wraps naturally at 2^XLEN; target low bits are forced to a word boundary.
    assign w_pcplus4            = r_pc + FOUR;
    assign w_target             = {pctarget[XLEN-1:2], 2'b00};
    assign w_unused_target_lsbs = &pctarget[1:0];

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_fetch_pc;
    assign instr       = r_instr;
    assign op          = r_instr[6:0];
    assign funct3      = r_instr[14:12];
    assign funct7b5    = r_instr[30];
    assign pc          = r_pc;
    assign pcplus4     = w_pcplus4;
    assign instr_valid = r_instr_valid;
    assign instret     = r_instret;

    // Fetch FSM: IDLE drains any stale ack after reset, REQ waits for the memory, VALID holds until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_pc          <= RESET_PC;
            r_instr       <= NOP;
            r_instret     <= 32'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_pc          <= r_fetch_pc;
                        r_state       <= S_VALID;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        r_fetch_pc    <= pcsrc ? w_target : w_pcplus4;
                        r_instret     <= r_instret + 32'd1;
                        r_state       <= S_REQ;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic [31:0] instret;

    logic        w_req2;
    logic [31:0] w_addr2;
    logic [31:0] w_instr2;
    logic [6:0]  w_op2;
    logic [2:0]  w_funct3_2;
    logic        w_funct7b5_2;
    logic [31:0] w_pc2;
    logic [31:0] w_pcplus4_2;
    logic        w_valid2;
    logic [31:0] w_instret2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] instret;
    } exp_t;

    exp_t sb[$];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .pcsrc(pcsrc), .pctarget(pctarget), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .pc(pc), .pcplus4(pcplus4), .instr_valid(instr_valid), .instret(instret)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .pcsrc(1'b0), .pctarget(32'h0), .stall(1'b0),
        .imem_req(w_req2), .imem_addr(w_addr2), .imem_ack(1'b1), .imem_rdata(32'h0050_0093),
        .instr(w_instr2), .op(w_op2), .funct3(w_funct3_2), .funct7b5(w_funct7b5_2),
        .pc(w_pc2), .pcplus4(w_pcplus4_2), .instr_valid(w_valid2), .instret(w_instret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc"}, pc, e.pc);
            check({tag, "_instr"}, instr, e.instr);
            check({tag, "_instret"}, instret, e.instret);
            check({tag, "_pcplus4"}, pcplus4, e.pc + 32'd4);
        end
    endtask

    initial begin
        reset = 1'b1; pcsrc = 1'b0; pctarget = 32'h0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        step();
        step();
        // reset state
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instret", instret, 32'd0);
        check("wrap_rst_addr", w_addr2, 32'hFFFF_FFFC);

        reset = 1'b0;
        step();
        check("req_cycle2", {31'd0, imem_req}, 32'd1);
        check("req_addr0", imem_addr, 32'h0);

        // back-to-back fetches with ack tied high
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.pc = 32'(i * 4); e.instr = 32'h0050_0093; e.instret = 32'(i);
            sb.push_back(e);
            wait_valid("seq");
            pop_compare("seq");
            if (i == 0) begin
                check("wrap_pc", w_pc2, 32'hFFFF_FFFC);
                check("wrap_pcplus4", w_pcplus4_2, 32'h0);
            end
            if (i == 2) imem_ack = 1'b0;
            step();
            check("seq_valid_drop", {31'd0, instr_valid}, 32'd0);
            check("seq_req_back", {31'd0, imem_req}, 32'd1);
            if (i == 0) check("wrap_addr2", w_addr2, 32'h0);
        end

        // delayed ack: request must hold steady
        for (int i = 0; i < 3; i++) begin
            check("hold_req", {31'd0, imem_req}, 32'd1);
            check("hold_addr", imem_addr, 32'd12);
            check("hold_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        imem_ack = 1'b1; imem_rdata = 32'h4000_8033;
        begin
            exp_t e;
            e.pc = 32'd12; e.instr = 32'h4000_8033; e.instret = 32'd3;
            sb.push_back(e);
        end
        wait_valid("late");
        pop_compare("late");
        check("dec_op", {25'd0, op}, 32'h33);
        check("dec_funct3", {29'd0, funct3}, 32'd0);
        check("dec_funct7b5", {31'd0, funct7b5}, 32'd1);

        // branch under stall is ignored, then taken when released
        stall = 1'b1; pcsrc = 1'b1; pctarget = 32'h0000_0103;
        step();
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_addr", imem_addr, 32'd12);
        check("stall_pc", pc, 32'd12);
        check("stall_instr", instr, 32'h4000_8033);
        check("stall_instret", instret, 32'd3);
        stall = 1'b0;
        step();
        pcsrc = 1'b0; pctarget = 32'h0;
        check("br_addr", imem_addr, 32'h0000_0100);
        check("br_req", {31'd0, imem_req}, 32'd1);
        check("br_instret", instret, 32'd4);
        imem_rdata = 32'h0050_0093;
        begin
            exp_t e;
            e.pc = 32'h100; e.instr = 32'h0050_0093; e.instret = 32'd4;
            sb.push_back(e);
        end
        wait_valid("br");
        pop_compare("br");

        // reset while a request is outstanding and acked
        step();
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        check("pre_rst_addr", imem_addr, 32'h104);
        reset = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0;
        check("mid_rst_instr", instr, 32'h0000_0013);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_instret", instret, 32'd0);
        step();
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_valid", {31'd0, instr_valid}, 32'd0);
        begin
            exp_t e;
            e.pc = 32'h0; e.instr = 32'hDEAD_BEEF; e.instret = 32'd0;
            sb.push_back(e);
        end
        wait_valid("restart");
        pop_compare("restart");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: XLEN, 32, data/address width; RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pcsrc  input  1  take-branch from control stage; valid only while instr_valid=1.
REQ-005 pctarget  input  XLEN  branch/jump target; bits [1:0] SHALL be ignored (treated as 00).
REQ-006 stall  input  1  downstream hold; 1 = current instruction not consumed.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  registered instruction.
REQ-012 op / funct3 / funct7b5  output  7/3/1  instr[6:0], instr[14:12], instr[30], combinational from instr.
REQ-013 pc / pcplus4  output  XLEN  address of instr, and pc+4.
REQ-014 instr_valid  output  1  instr/pc are valid for the control stage.
REQ-015 instret  output  32  count of consumed instructions.

Function
REQ-016 FSM SHALL have states IDLE, REQ, VALID; reset SHALL enter IDLE.
REQ-017 IDLE: imem_req=0, imem_ack ignored; next state REQ unconditionally (one cycle).
REQ-018 REQ: imem_req=1, imem_addr=fetch PC; imem_addr SHALL stay stable until imem_ack.
REQ-019 REQ with imem_ack=1: instr<=imem_rdata, pc<=fetch PC, next state VALID; without ack, remain in REQ.
REQ-020 VALID: instr_valid=1, imem_req=0; imem_ack SHALL be ignored.
REQ-021 VALID with stall=1: instr, pc, fetch PC, instret SHALL hold; pcsrc SHALL be ignored.
REQ-022 VALID with stall=0: instruction consumed; fetch PC <= pcsrc ? {pctarget[XLEN-1:2],2'b00} : pc+4; instret <= instret+1; next state REQ.
REQ-023 Minimum latency: 2 cycles per instruction (REQ with same-cycle ack, then VALID).
REQ-024 pc+4 arithmetic SHALL be modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-026 pcplus4 SHALL equal pc+4 (modulo 2^XLEN) at all times.

Reset
REQ-027 While reset=1 at a clock edge, next cycle: state=IDLE, fetch PC=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, imem_addr=RESET_PC, instret=0.
REQ-028 Reset SHALL take priority over every other input, including an in-flight imem_ack and pcsrc.
REQ-029 Reset during REQ SHALL abandon the outstanding request; the IDLE cycle guarantees no stale ack is accepted.

Verification
REQ-030 Reset, imem_ack tied 1 with imem_rdata=32'h0050_0093, stall=0, pcsrc=0 -> imem_req high at cycle 2; instr_valid pulses on alternating cycles with pc 0,4,8; instret increments by 1 per consume.
REQ-031 imem_ack delayed 3 cycles in REQ -> imem_req and imem_addr held constant for 3 cycles, instr_valid=0 until the cycle after the ack.
REQ-032 VALID with pcsrc=1, pctarget=32'h0000_0103, stall=0 -> next imem_addr=32'h0000_0100; with stall=1 at the same time, imem_addr unchanged and instr/pc held.
REQ-033 RESET_PC=32'hFFFF_FFFC, pcsrc=0 -> second fetch address 32'h0000_0000, pcplus4 of first instr = 0.
REQ-034 Assert reset during REQ with imem_ack=1 in the reset cycle -> instr stays 32'h0000_0013, instr_valid=0, imem_req=0 for one cycle, then fetch restarts at RESET_PC.
REQ-035 Drive imem_rdata=32'h4000_8033 into VALID -> op=7'h33, funct3=3'b000, funct7b5=1.
